// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle MULT/DIV engine.
//   state_t : FSM state encoding (IDLE -> RUN -> FIX -> DONE)
//   MD_MULT / MD_DIV : operation select values for div_or_mult
//   clog2() : counter width helper
package mult_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/md_step.sv
// One combinational iteration of the shared datapath.
//   op        : MD_MULT = radix-2 Booth step, MD_DIV = restoring-division step
//   acc       : Booth A (WIDTH+1, signed) / division partial remainder
//   m         : sign-extended multiplicand / zero-extended divisor magnitude
//   q, q_m1   : Booth Q and q-1 / quotient shift register (q_m1 unused for DIV)
//   *_next_c  : values for the next iteration
module md_step
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             op,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH:0]   m,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    output logic [WIDTH:0]   acc_next_c,
    output logic [WIDTH-1:0] q_next_c,
    output logic             q_m1_next_c
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] quo_sh;

    always_comb begin
        sum         = acc;
        rem_sh      = {acc[WIDTH-1:0], q[WIDTH-1]};
        quo_sh      = {q[WIDTH-2:0], 1'b0};
        acc_next_c  = acc;
        q_next_c    = q;
        q_m1_next_c = q_m1;

        if (op == MD_MULT) begin
            // Booth recode on {Q[0], q-1}, then arithmetic shift of {A, Q, q-1}.
            case ({q[0], q_m1})
                2'b01:   sum = acc + m;
                2'b10:   sum = acc - m;
                default: sum = acc;
            endcase
            acc_next_c  = {sum[WIDTH], sum[WIDTH:1]};
            q_next_c    = {sum[0], q[WIDTH-1:1]};
            q_m1_next_c = q[0];
        end else begin
            // Shift {R, Q} left and commit the trial subtraction when it fits.
            if (rem_sh >= m) begin
                acc_next_c = rem_sh - m;
                q_next_c   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next_c = rem_sh;
                q_next_c   = quo_sh;
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV engine feeding the HI/LO registers.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   start, div_or_mult: request (sampled in IDLE only) and op select (0 MULT, 1 DIV)
//   a_in, b_in        : multiplicand/dividend and multiplier/divisor
//   busy              : high in RUN and FIX
//   done, div_zero    : one-cycle completion pulse; div_zero flags DIV by zero
//   hi_out, lo_out    : MULT product high/low, or DIV remainder/quotient
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             div_or_mult,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned CNT_W = clog2(WIDTH);

    state_t           state;
    logic             op;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   acc_step_c;
    logic [WIDTH-1:0] q_step_c;
    logic             q_m1_step_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH-1:0] quot_fix_c;
    logic [WIDTH-1:0] rem_fix_c;

    md_step #(.WIDTH(WIDTH)) u_step (
        .op          (op),
        .acc         (acc),
        .m           (m),
        .q           (q),
        .q_m1        (q_m1),
        .acc_next_c  (acc_step_c),
        .q_next_c    (q_step_c),
        .q_m1_next_c (q_m1_step_c)
    );

    // Operand magnitudes (0x80000000 maps to unsigned 2^31) and DIV sign fix-up.
    always_comb begin
        a_mag_c    = a_in[WIDTH-1] ? -a_in : a_in;
        b_mag_c    = b_in[WIDTH-1] ? -b_in : b_in;
        quot_fix_c = (sign_a ^ sign_b) ? -q : q;
        rem_fix_c  = sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            count    <= '0;
            op       <= MD_MULT;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            acc      <= '0;
            m        <= '0;
            q        <= '0;
            q_m1     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op     <= div_or_mult;
                        sign_a <= a_in[WIDTH-1];
                        sign_b <= b_in[WIDTH-1];
                        count  <= '0;
                        acc    <= '0;
                        q_m1   <= 1'b0;
                        if (div_or_mult == MD_DIV) begin
                            q <= a_mag_c;
                            m <= {1'b0, b_mag_c};
                            if (b_in == '0) begin
                                // Divide by zero skips the datapath; HI/LO keep old values.
                                state    <= ST_DONE;
                                done     <= 1'b1;
                                div_zero <= 1'b1;
                            end else begin
                                state <= ST_RUN;
                                busy  <= 1'b1;
                            end
                        end else begin
                            q     <= b_in;
                            m     <= {a_in[WIDTH-1], a_in};
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    acc   <= acc_step_c;
                    q     <= q_step_c;
                    q_m1  <= q_m1_step_c;
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (op == MD_DIV) begin
                        hi_out <= rem_fix_c;
                        lo_out <= quot_fix_c;
                    end else begin
                        hi_out <= acc[WIDTH-1:0];
                        lo_out <= q;
                    end
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// MULT/DIV traffic compared against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

    localparam int unsigned WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             div_or_mult;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .div_or_mult (div_or_mult),
        .a_in        (a_in),
        .b_in        (b_in),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed 64-bit product, or truncating division with remainder sign of dividend.
    function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] old_hi, input logic [31:0] old_lo,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dz);
        longint sa, sb, p, ma, mb, qq, rr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        if (op == 1'b0) begin
            p  = sa * sb;
            hi = 32'(p >>> 32);
            lo = 32'(p);
        end else if (b == 32'd0) begin
            hi = old_hi;
            lo = old_lo;
            dz = 1'b1;
        end else begin
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            qq = ma / mb;
            rr = ma % mb;
            if ((sa < 0) != (sb < 0)) qq = -qq;
            if (sa < 0) rr = -rr;
            lo = 32'(qq);
            hi = 32'(rr);
        end
    endfunction

    // Launch one operation, scramble operands after the start edge, check latency and results.
    task automatic run_and_check(input string tag, input logic op,
                                 input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e_hi, e_lo;
        logic        e_dz;
        int          lat;
        model(op, a, b, prev_hi, prev_lo, e_hi, e_lo, e_dz);
        @(negedge clock);
        start = 1'b1; div_or_mult = op; a_in = a; b_in = b;
        @(posedge clock); #1;
        start = 1'b0; div_or_mult = ~op; a_in = $urandom; b_in = $urandom;
        chk({tag, ".busy"}, 64'(busy), 64'(!e_dz));
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), e_dz ? 64'd0 : 64'd33);
        chk({tag, ".div_zero"}, 64'(div_zero), 64'(e_dz));
        chk({tag, ".hi"}, 64'(hi_out), 64'(e_hi));
        chk({tag, ".lo"}, 64'(lo_out), 64'(e_lo));
        chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clock); #1;
        chk({tag, ".done_pulse"}, 64'({done, div_zero}), 64'd0);
        prev_hi = e_hi;
        prev_lo = e_lo;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic        rop;
        logic [31:0] ra, rb;
        logic        saw_done;

        reset = 1'b1; start = 1'b0; div_or_mult = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset.flags", 64'({busy, done, div_zero}), 64'd0);
        chk("reset.hi", 64'(hi_out), 64'd0);
        chk("reset.lo", 64'(lo_out), 64'd0);
        reset = 1'b0;

        run_and_check("mult_7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD);
        run_and_check("mult_min_sq", 1'b0, 32'h8000_0000, 32'h8000_0000);
        run_and_check("div_-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_and_check("div_set_11_22", 1'b1, 32'h0000_0451, 32'h0000_0020);
        chk("preset.hi", 64'(hi_out), 64'h11);
        chk("preset.lo", 64'(lo_out), 64'h22);
        run_and_check("div_100/0", 1'b1, 32'd100, 32'd0);
        run_and_check("div_min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_and_check("div_small/big", 1'b1, 32'd5, 32'hFFFF_FF00);

        for (int i = 0; i < 24; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 :
                  ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 40)) : $urandom;
            run_and_check($sformatf("rand%0d", i), rop, ra, rb);
        end

        // Abort mid-operation: second start ignored, reset discards the result.
        saw_done = 1'b0;
        @(negedge clock);
        start = 1'b1; div_or_mult = 1'b0; a_in = 32'd5; b_in = 32'd6;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock); #1;
            if (done) saw_done = 1'b1;
            start = 1'b0;
            if (c == 9) begin
                start = 1'b1; div_or_mult = 1'b1; a_in = 32'd9; b_in = 32'd0;
                chk("abort.hi_hold", 64'(hi_out), 64'(prev_hi));
                chk("abort.lo_hold", 64'(lo_out), 64'(prev_lo));
            end
            if (c == 18) chk("abort.busy_running", 64'(busy), 64'd1);
            if (c == 19) reset = 1'b1;
        end
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort.flags", 64'({busy, done, div_zero}), 64'd0);
        chk("abort.hi", 64'(hi_out), 64'd0);
        chk("abort.lo", 64'(lo_out), 64'd0);
        repeat (40) begin
            @(posedge clock); #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort.no_done", 64'(saw_done), 64'd0);
        prev_hi = '0;
        prev_lo = '0;
        run_and_check("mult_5x6_after_reset", 1'b0, 32'd5, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
